// File: rtl/vk_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vk_mem_arbiter_if
// Bundle of the keyboard, VGA-refresh and memory-port signals seen by
// vk_mem_arbiter.
//   slave  modport : the arbiter itself
//   master modport : the environment (keyboard decoder, VGA reader, RAM)
// Signals:
//   key_valid/key_data/key_ready   keystroke push handshake
//   vga_req/vga_addr/vga_gnt       refresh read request, held until granted
//   vga_rdata/vga_rvalid           refresh read return
//   mem_addr/mem_wren/mem_wdata    registered shared memory port
//   mem_rdata                      synchronous RAM read data (1-cycle)
//   key_overflow                   sticky keystroke-dropped flag
// ---------------------------------------------------------------------------
interface vk_mem_arbiter_if;
   logic        key_valid;
   logic [31:0] key_data;
   logic        key_ready;
   logic        vga_req;
   logic [31:0] vga_addr;
   logic        vga_gnt;
   logic [31:0] vga_rdata;
   logic        vga_rvalid;
   logic [31:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        key_overflow;

   modport slave (
      input  key_valid, key_data, vga_req, vga_addr, mem_rdata,
      output key_ready, vga_gnt, vga_rdata, vga_rvalid,
             mem_addr, mem_wren, mem_wdata, key_overflow
   );

   modport master (
      output key_valid, key_data, vga_req, vga_addr, mem_rdata,
      input  key_ready, vga_gnt, vga_rdata, vga_rvalid,
             mem_addr, mem_wren, mem_wdata, key_overflow
   );
endinterface

// File: rtl/vk_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vk_mem_arbiter
// Arbitrates the single shared VGA/keyboard memory port. Keystrokes are
// buffered in a small FIFO; each cycle at most one slot is granted: a VGA
// refresh read, a keystroke write to the key mailbox, or idle.
//
// Ports:
//   sys_clk  system clock, rising edge
//   rst      asynchronous active-low reset
//   bus      vk_mem_arbiter_if.slave (key, VGA and memory signals)
//
// Parameters:
//   KEY_ADDR    word address of the key mailbox
//   FIFO_DEPTH  keystroke FIFO entries (power of two, 2..16)
//   MAX_WAIT    consecutive VGA grants tolerated while keys wait
//
// Build option:
//   VK_ARB_STARVE_GUARD_EN  defined   -> after MAX_WAIT consecutive VGA grants
//                                        with keys pending, a key write wins
//                           undefined -> VGA has strict priority
// ---------------------------------------------------------------------------
module vk_mem_arbiter #(
   parameter logic [31:0] KEY_ADDR   = 32'h0000_20D0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_WAIT   = 8
) (
   input  logic             sys_clk,
   input  logic             rst,
   vk_mem_arbiter_if.slave  bus
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      SLOT_IDLE   = 2'd0,
      SLOT_KEY_WR = 2'd1,
      SLOT_VGA_RD = 2'd2
   } slot_e;

   // Keystroke FIFO
   logic [31:0]      r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   // Memory port and status registers
   logic [31:0]      r_mem_addr;
   logic             r_mem_wren;
   logic [31:0]      r_mem_wdata;
   logic [1:0]       r_rv_pipe;
   logic             r_overflow;

   logic             w_empty;
   logic             w_full;
   logic             w_key_ok;
   logic             w_push;
   logic             w_pop;
   logic             w_wait_hit;
   slot_e            w_slot;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
   // A zero code is "no key": neither pushed nor counted as an overflow.
   assign w_key_ok = bus.key_valid && (bus.key_data != 32'd0);
   // Full means full: a pop on the same edge does not make room.
   assign w_push   = w_key_ok && !w_full;
   assign w_pop    = (w_slot == SLOT_KEY_WR);

`ifdef VK_ARB_STARVE_GUARD_EN
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] r_wait_cnt;

   assign w_wait_hit = (r_wait_cnt == WAIT_W'(MAX_WAIT));

   // Counts VGA grants taken while keys are waiting; any key write or an
   // empty FIFO restarts the count.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_wait_cnt <= '0;
      end else if (w_empty || (w_slot == SLOT_KEY_WR)) begin
         r_wait_cnt <= '0;
      end else if ((w_slot == SLOT_VGA_RD) && !w_wait_hit) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end
`else
   logic w_unused_cfg;

   assign w_wait_hit   = 1'b0;
   assign w_unused_cfg = ^MAX_WAIT;
`endif

   // Slot arbitration: pending keys win when VGA is quiet or has used up
   // its allowance; otherwise a VGA request takes the slot.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_slot = SLOT_IDLE;
      if (!w_empty && (!bus.vga_req || w_wait_hit)) begin
         w_slot = SLOT_KEY_WR;
      end else if (bus.vga_req) begin
         w_slot = SLOT_VGA_RD;
      end
   end

   // Gated with reset so no grant is reported while the block is held.
   assign bus.vga_gnt   = rst && bus.vga_req && (w_slot == SLOT_VGA_RD);
   assign bus.key_ready = !w_full;

   // FIFO pointers and occupancy
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the FIFO storage has no reset; resetting the pointers and count
   // already discards its contents, and a reset-free array maps to RAM.
   always_ff @(posedge sys_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= bus.key_data;
      end
   end

   // Memory port registers, read-valid pipeline and sticky overflow
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_mem_addr  <= '0;
         r_mem_wren  <= 1'b0;
         r_mem_wdata <= '0;
         r_rv_pipe   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         unique case (w_slot)
            SLOT_KEY_WR: begin
               r_mem_addr  <= KEY_ADDR;
               r_mem_wren  <= 1'b1;
               r_mem_wdata <= r_fifo[r_rd_ptr];
            end
            SLOT_VGA_RD: begin
               r_mem_addr <= bus.vga_addr;
               r_mem_wren <= 1'b0;
            end
            default: begin
               r_mem_wren <= 1'b0;
            end
         endcase
         // Stage 0: address presented; stage 1: RAM data on mem_rdata.
         r_rv_pipe <= {r_rv_pipe[0], bus.vga_gnt};
         if (w_key_ok && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_wren     = r_mem_wren;
   assign bus.mem_wdata    = r_mem_wdata;
   assign bus.vga_rvalid   = r_rv_pipe[1];
   assign bus.vga_rdata    = bus.mem_rdata;
   assign bus.key_overflow = r_overflow;

endmodule

// File: tb/tb_vk_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vk_mem_arbiter
// Self-checking bench for vk_mem_arbiter. A behavioural model (key queue,
// pending-read queue, grant allowance counter) predicts every output cycle
// by cycle. The RAM is modelled as synchronous with contents equal to the
// address.
// ---------------------------------------------------------------------------
module tb_vk_mem_arbiter;

   localparam logic [31:0] KEY_ADDR   = 32'h0000_20D0;
   localparam int          FIFO_DEPTH = 4;
   localparam int          MAX_WAIT   = 8;
`ifdef VK_ARB_STARVE_GUARD_EN
   localparam bit          GUARD      = 1'b1;
`else
   localparam bit          GUARD      = 1'b0;
`endif

   logic sys_clk = 1'b0;
   logic rst     = 1'b0;

   always #5 sys_clk = ~sys_clk;

   vk_mem_arbiter_if bus ();

   vk_mem_arbiter #(
      .KEY_ADDR   (KEY_ADDR),
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_WAIT   (MAX_WAIT)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   // Synchronous RAM preloaded with data == address
   always @(posedge sys_clk) bus.mem_rdata <= bus.mem_addr;

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] addr;
   } rd_t;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] key_q [$];
   rd_t         rd_q  [$];
   int          cycle    = 0;
   int          wait_cnt = 0;
   logic [31:0] exp_addr  = '0;
   logic [31:0] exp_wdata = '0;
   logic        exp_wren  = 1'b0;
   logic        exp_ovf   = 1'b0;
   logic        last_gnt  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   task automatic model_reset();
      key_q.delete();
      rd_q.delete();
      wait_cnt  = 0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_wren  = 1'b0;
      exp_ovf   = 1'b0;
      last_gnt  = 1'b0;
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the
   // model across the edge, check registered outputs.
   task automatic step(input logic vreq, input logic [31:0] vaddr,
                       input logic kv, input logic [31:0] kd);
      logic full, was_empty, key_wr, gnt, exp_rv;
      rd_t  r;
      @(negedge sys_clk);
      bus.vga_req   = vreq;
      bus.vga_addr  = vaddr;
      bus.key_valid = kv;
      bus.key_data  = kd;
      #1;
      full      = (key_q.size() == FIFO_DEPTH);
      was_empty = (key_q.size() == 0);
      key_wr    = !was_empty && (!vreq || (GUARD && wait_cnt == MAX_WAIT));
      gnt       = vreq && !key_wr;
      check("key_ready", bus.key_ready, !full);
      check("vga_gnt", bus.vga_gnt, gnt);
      last_gnt = gnt;

      @(posedge sys_clk);
      cycle++;
      if (key_wr) begin
         exp_addr  = KEY_ADDR;
         exp_wren  = 1'b1;
         exp_wdata = key_q.pop_front();
      end else if (gnt) begin
         exp_addr = vaddr;
         exp_wren = 1'b0;
         r.due    = cycle + 1;
         r.addr   = vaddr;
         rd_q.push_back(r);
      end else begin
         exp_wren = 1'b0;
      end
      if (was_empty || key_wr) wait_cnt = 0;
      else if (gnt && wait_cnt < MAX_WAIT) wait_cnt++;
      if (kv && kd != 0) begin
         if (!full) key_q.push_back(kd);
         else exp_ovf = 1'b1;
      end

      #1;
      check("mem_addr", bus.mem_addr, exp_addr);
      check("mem_wren", bus.mem_wren, exp_wren);
      check("mem_wdata", bus.mem_wdata, exp_wdata);
      check("key_overflow", bus.key_overflow, exp_ovf);
      exp_rv = (rd_q.size() != 0) && (rd_q[0].due == cycle);
      check("vga_rvalid", bus.vga_rvalid, exp_rv);
      if (exp_rv) begin
         check("vga_rdata", bus.vga_rdata, rd_q[0].addr);
         void'(rd_q.pop_front());
      end
   endtask

   // Assert reset away from the clock edge, check the held state, release.
   task automatic apply_reset();
      @(negedge sys_clk);
      #2;
      rst           = 1'b0;
      bus.vga_req   = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_data  = 32'h55;
      model_reset();
      #1;
      check("rst_mem_wren", bus.mem_wren, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_vga_rvalid", bus.vga_rvalid, 1'b0);
      check("rst_key_overflow", bus.key_overflow, 1'b0);
      check("rst_key_ready", bus.key_ready, 1'b1);
      check("rst_vga_gnt", bus.vga_gnt, 1'b0);
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_hold_vga_rvalid", bus.vga_rvalid, 1'b0);
      check("rst_hold_mem_wren", bus.mem_wren, 1'b0);
      @(negedge sys_clk);
      bus.vga_req   = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_data  = 32'h0;
      rst           = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        vreq;
      logic [31:0] vaddr;
      int          pct;

      bus.vga_req   = 1'b0;
      bus.vga_addr  = 32'h0;
      bus.key_valid = 1'b0;
      bus.key_data  = 32'h0;

      // Reset with idle inputs, then release
      apply_reset();
      step(1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0);

      // Continuous refresh 0x100..0x102, data returns in order
      for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + i, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0);

      // Single key with VGA idle: one write cycle to the mailbox
      step(1'b0, 32'h0, 1'b1, 32'h41);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      check("key_fifo_empty_after_write", bus.key_ready, 1'b1);

      // Zero key code: ignored, no overflow
      step(1'b0, 32'h0, 1'b1, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0);

`ifdef VK_ARB_STARVE_GUARD_EN
      // One key under continuous refresh: MAX_WAIT grants, one key write,
      // then grants resume
      step(1'b1, 32'h200, 1'b1, 32'h61);
      for (int i = 1; i < MAX_WAIT + 5; i++) step(1'b1, 32'h200 + i, 1'b0, 32'h0);
`else
      // Five keys under continuous refresh: fifth dropped, overflow sticky,
      // four writes in push order once refresh stops
      for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + i, 1'b1, 32'h31 + i);
      for (int i = 5; i < 7; i++) step(1'b1, 32'h200 + i, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
`endif

      // Reset one cycle after a VGA acceptance with keys buffered
      for (int i = 0; i < 3; i++) step(1'b1, 32'h280 + i, 1'b1, 32'h71 + i);
      step(1'b1, 32'h300, 1'b0, 32'h0);
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 32'h0);

      // Randomized traffic; VGA requests held with their address until granted
      vreq  = 1'b0;
      vaddr = 32'h0;
      for (int i = 0; i < 800; i++) begin
         pct = ((i / 60) % 2 == 0) ? 95 : 35;
         if (!(vreq && !last_gnt)) begin
            vreq  = ($urandom_range(99) < pct);
            vaddr = $urandom;
         end
         step(vreq, vaddr,
              ($urandom_range(99) < 40),
              ($urandom_range(9) == 0) ? 32'h0 : 32'($urandom_range(127, 1)));
      end
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
      check("drain_pending_reads", rd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
